// File: rtl/cache_token_ctrl_pkg.sv
// Shared cache definitions: address fields, ring token and controller state encoding.
package cache_token_ctrl_pkg;

  localparam int TAG_W   = 8;
  localparam int INDEX_W = 4;

  typedef logic [TAG_W-1:0]   addr_tag;
  typedef logic [INDEX_W-1:0] addr_index;

  typedef struct packed {
    logic      valid;
    addr_tag   tag;
    addr_index index;
  } ring_token;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TOKEN,
    WAIT_RETURN,
    LOCKED
  } ctrl_state;

  // True when a token coming back off the ring is the one this core launched.
  function automatic logic token_hits(ring_token t, addr_tag tag, addr_index index);
    return t.valid && (t.tag == tag) && (t.index == index);
  endfunction

endpackage

// File: rtl/cache_wait_counter.sv
// Saturating wait counter with synchronous clear and count enable; flags when the limit is reached.
module cache_wait_counter #(
  parameter int WAIT_W       = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam logic [WAIT_W-1:0] COUNT_MAX = '1;
  localparam logic [WAIT_W-1:0] LIMIT     = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != COUNT_MAX)) begin
      count <= count + WAIT_W'(1);
    end
  end

  assign at_limit = (count >= LIMIT);

endmodule

// File: rtl/cache_token_ctrl.sv
// Per-core token-ring sequencer: accept one request, wait for the slot, launch, await return, optional lock hold.
// Optional macro CACHE_TOKEN_CTRL_ASSERT_EN adds protocol assertions; behaviour is unchanged without it.
module cache_token_ctrl
  import cache_token_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 64,
  parameter int WAIT_W       = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      req_valid,
  output logic      req_ready,
  input  addr_tag   req_tag,
  input  addr_index req_index,
  input  logic      req_lock,
  input  logic      unlock,
  output logic      done,
  output addr_tag   core_tag,
  output addr_index core_index,
  input  logic      may_send,
  input  logic      locked,
  output logic      send,
  output logic      lock_line,
  output logic      unlock_line,
  output logic      ring_send,
  input  logic      ring_ret_valid,
  input  addr_tag   ring_ret_tag,
  input  addr_index ring_ret_index,
  output logic      starve,
  output logic      busy
);

  ctrl_state state;
  logic      lock_q;
  logic      wait_at_limit;
  logic      ret_hit;
  ring_token ret_tok;

  assign ret_tok = '{valid: ring_ret_valid, tag: ring_ret_tag, index: ring_ret_index};
  assign ret_hit = token_hits(ret_tok, core_tag, core_index);

  // Request handshake: a request transfers on any cycle with req_valid && req_ready;
  // req_ready is high only in IDLE, so at most one request is ever in flight.
  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign send        = (state == WAIT_TOKEN) && may_send;
  assign ring_send   = send;
  assign lock_line   = send && lock_q;
  assign done        = (state == WAIT_RETURN) && ret_hit;
  assign unlock_line = (state == LOCKED) && unlock;
  assign starve      = (state == WAIT_TOKEN) && wait_at_limit;

  cache_wait_counter #(
    .WAIT_W      (WAIT_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_wait_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state == IDLE) && req_valid),
    .en      ((state == WAIT_TOKEN) && !may_send),
    .at_limit(wait_at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      core_tag   <= '0;
      core_index <= '0;
      lock_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            core_tag   <= req_tag;
            core_index <= req_index;
            lock_q     <= req_lock;
            state      <= WAIT_TOKEN;
          end
        end
        WAIT_TOKEN: begin
          if (may_send) state <= WAIT_RETURN;
        end
        WAIT_RETURN: begin
          if (ret_hit) state <= lock_q ? LOCKED : IDLE;
        end
        LOCKED: begin
          if (unlock) begin
            lock_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_TOKEN_CTRL_ASSERT_EN
  ctrl_state state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_d <= IDLE;
    else        state_d <= state;
  end

  a_send_needs_may_send: assert property (@(posedge clk) disable iff (!rst_n)
    send |-> may_send);

  // The slot needs one cycle after entry to reflect the lock.
  a_locked_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    ((state == LOCKED) && (state_d == LOCKED)) |-> locked);

  a_unlock_only_locked: assert property (@(posedge clk) disable iff (!rst_n)
    unlock_line |-> (state == LOCKED));
`else
  logic unused_locked;
  assign unused_locked = locked;
`endif

endmodule

// File: tb/tb_cache_token_ctrl.sv
// Directed bench for cache_token_ctrl: transaction-level model checked every cycle plus literal spot checks.
module tb_cache_token_ctrl;
  import cache_token_ctrl_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      req_valid;
  logic      req_ready;
  addr_tag   req_tag;
  addr_index req_index;
  logic      req_lock;
  logic      unlock;
  logic      done;
  addr_tag   core_tag;
  addr_index core_index;
  logic      may_send;
  logic      locked;
  logic      send;
  logic      lock_line;
  logic      unlock_line;
  logic      ring_send;
  logic      ring_ret_valid;
  addr_tag   ring_ret_tag;
  addr_index ring_ret_index;
  logic      starve;
  logic      busy;

  int errors = 0;
  int checks = 0;

  cache_token_ctrl #(.STARVE_LIMIT(64), .WAIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_index(req_index), .req_lock(req_lock), .unlock(unlock), .done(done),
    .core_tag(core_tag), .core_index(core_index), .may_send(may_send),
    .locked(locked), .send(send), .lock_line(lock_line), .unlock_line(unlock_line),
    .ring_send(ring_send), .ring_ret_valid(ring_ret_valid), .ring_ret_tag(ring_ret_tag),
    .ring_ret_index(ring_ret_index), .starve(starve), .busy(busy)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request is outstanding until its token returns, then
  // optionally held until unlock. Waiting time counts cycles denied by the slot.
  logic      m_pending, m_sent, m_holding, m_lock;
  int        m_waited;
  addr_tag   m_tag;
  addr_index m_index;

  task automatic model_reset();
    m_pending = 0; m_sent = 0; m_holding = 0; m_lock = 0;
    m_waited = 0; m_tag = '0; m_index = '0;
  endtask

  task automatic model_step();
    logic own_return;
    own_return = ring_ret_valid && ring_ret_tag == m_tag && ring_ret_index == m_index;
    if (m_holding) begin
      if (unlock) m_holding = 0;
    end else if (!m_pending) begin
      if (req_valid) begin
        m_pending = 1; m_sent = 0; m_waited = 0;
        m_tag = req_tag; m_index = req_index; m_lock = req_lock;
      end
    end else if (!m_sent) begin
      if (may_send) m_sent = 1;
      else m_waited = (m_waited < 255) ? m_waited + 1 : 255;
    end else if (own_return) begin
      m_pending = 0;
      m_holding = m_lock;
    end
  endtask

  task automatic compare_all();
    logic idle, launching, returning;
    idle      = !m_pending && !m_holding;
    launching = m_pending && !m_sent && may_send;
    returning = m_pending && m_sent && ring_ret_valid &&
                ring_ret_tag == m_tag && ring_ret_index == m_index;
    check("m_req_ready",   32'(req_ready),   32'(idle));
    check("m_busy",        32'(busy),        32'(!idle));
    check("m_send",        32'(send),        32'(launching));
    check("m_ring_send",   32'(ring_send),   32'(launching));
    check("m_lock_line",   32'(lock_line),   32'(launching && m_lock));
    check("m_done",        32'(done),        32'(returning));
    check("m_unlock_line", 32'(unlock_line), 32'(m_holding && unlock));
    check("m_starve",      32'(starve),      32'(m_pending && !m_sent && m_waited >= 64));
    check("m_core_tag",    32'(core_tag),    32'(m_tag));
    check("m_core_index",  32'(core_index),  32'(m_index));
  endtask

  // scoreboard / compare process
  initial model_reset();
  always begin
    @(negedge clk);
    if (!rst_n) model_reset();
    compare_all();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    locked = m_holding;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input addr_tag t, input addr_index i, input logic lk);
    req_valid = 1'b1; req_tag = t; req_index = i; req_lock = lk;
  endtask

  task automatic ret(input logic v, input addr_tag t, input addr_index i);
    ring_ret_valid = v; ring_ret_tag = t; ring_ret_index = i;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_tag = '0; req_index = '0; req_lock = 1'b0;
    unlock = 1'b0; may_send = 1'b0; locked = 1'b0;
    ring_ret_valid = 1'b0; ring_ret_tag = '0; ring_ret_index = '0;
    repeat (2) tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_starve",    32'(starve),    32'd0);
    rst_n = 1'b1;
    tick();

    // Plain request with the slot already free
    may_send = 1'b1;
    issue(8'h12, 4'd3, 1'b0);
    tick();
    req_valid = 1'b0;
    #1;
    check("t1_send",      32'(send),      32'd1);
    check("t1_ring_send", 32'(ring_send), 32'd1);
    check("t1_lock_line", 32'(lock_line), 32'd0);
    check("t1_core_tag",  32'(core_tag),  32'h12);
    repeat (4) tick();
    ret(1'b1, 8'h12, 4'd3);
    #1;
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    ret(1'b0, 8'h00, 4'd0);
    #1;
    check("t1_busy_clr", 32'(busy),      32'd0);
    check("t1_ready",    32'(req_ready), 32'd1);

    // Return coinciding with launch, then non-matching returns
    issue(8'h12, 4'd3, 1'b0);
    tick();
    req_valid = 1'b0;
    ret(1'b1, 8'h12, 4'd3);
    #1;
    check("t4_same_send", 32'(send), 32'd1);
    check("t4_same_done", 32'(done), 32'd0);
    tick();
    ret(1'b1, 8'h13, 4'd3);
    #1;
    check("t4_tag_miss", 32'(done), 32'd0);
    tick();
    ret(1'b1, 8'h12, 4'd4);
    #1;
    check("t4_idx_miss", 32'(done), 32'd0);
    tick();
    ret(1'b1, 8'h12, 4'd3);
    #1;
    check("t4_hit", 32'(done), 32'd1);
    tick();
    ret(1'b0, 8'h00, 4'd0);

    // Starvation, with stray unlocks in IDLE and WAIT_TOKEN
    may_send = 1'b0;
    unlock = 1'b1;
    issue(8'h40, 4'd7, 1'b0);
    #1;
    check("t5_unlock_idle", 32'(unlock_line), 32'd0);
    tick();
    req_valid = 1'b0;
    #1;
    check("t5_unlock_wait", 32'(unlock_line), 32'd0);
    unlock = 1'b0;
    repeat (63) tick();
    check("t2_starve_63", 32'(starve), 32'd0);
    tick();
    check("t2_starve_64", 32'(starve), 32'd1);
    repeat (6) tick();
    may_send = 1'b1;
    #1;
    check("t2_send",      32'(send),   32'd1);
    check("t2_starve_70", 32'(starve), 32'd1);
    tick();
    check("t2_starve_off", 32'(starve), 32'd0);
    ret(1'b1, 8'h40, 4'd7);
    #1;
    check("t2_done", 32'(done), 32'd1);
    tick();
    ret(1'b0, 8'h00, 4'd0);

    // Locked sequence
    issue(8'h55, 4'd2, 1'b1);
    tick();
    req_valid = 1'b0;
    #1;
    check("t3_send",      32'(send),      32'd1);
    check("t3_lock_line", 32'(lock_line), 32'd1);
    tick();
    ret(1'b1, 8'h55, 4'd2);
    #1;
    check("t3_done", 32'(done), 32'd1);
    tick();
    ret(1'b0, 8'h00, 4'd0);
    #1;
    check("t3_ready_lk", 32'(req_ready), 32'd0);
    check("t3_busy_lk",  32'(busy),      32'd1);
    repeat (2) tick();
    check("t3_still_lk", 32'(req_ready), 32'd0);
    unlock = 1'b1;
    #1;
    check("t3_unlock_line", 32'(unlock_line), 32'd1);
    tick();
    unlock = 1'b0;
    #1;
    check("t3_ready_rel",  32'(req_ready),   32'd1);
    check("t3_unlock_off", 32'(unlock_line), 32'd0);

    // Asynchronous reset while waiting for the return
    issue(8'h21, 4'd5, 1'b1);
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_busy",       32'(busy),       32'd0);
    check("t6_ready",      32'(req_ready),  32'd1);
    check("t6_core_tag",   32'(core_tag),   32'd0);
    check("t6_core_index", 32'(core_index), 32'd0);
    check("t6_send",       32'(send),       32'd0);
    tick();
    rst_n = 1'b1;
    issue(8'h21, 4'd5, 1'b0);
    tick();
    req_valid = 1'b0;
    #1;
    check("t6_send_after",  32'(send),      32'd1);
    check("t6_lock_after",  32'(lock_line), 32'd0);
    tick();
    ret(1'b1, 8'h21, 4'd5);
    #1;
    check("t6_done", 32'(done), 32'd1);
    tick();
    ret(1'b0, 8'h00, 4'd0);
    #1;
    check("t6_idle", 32'(busy), 32'd0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_token_ctrl.md
Name: cache_token_ctrl

Overview:
- Per-core sequencer that drives the cache token-ring slot (send/lock_line/unlock_line, core_tag/core_index) for one cache controller.
- Accepts one coherence request at a time from the core-side cache FSM and waits until the slot reports may_send.
- Issues the ring request, waits for it to come back around the ring, and optionally holds the line locked for atomic sequences until an explicit unlock.

Parameters:
- STARVE_LIMIT, 64, cycles in WAIT_TOKEN after which starve asserts.
- WAIT_W, 8, width of the wait counter; the counter saturates at 2**WAIT_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  1  core request present
- req_ready  out  1  request accepted this cycle
- req_tag  in  addr_tag  request tag
- req_index  in  addr_index  request index
- req_lock  in  1  request starts a locked (atomic) sequence
- unlock  in  1  release locked line (LOCKED state only)
- done  out  1  one-cycle pulse: own request returned
- core_tag  out  addr_tag  registered tag to token slot
- core_index  out  addr_index  registered index to token slot
- may_send  in  1  from token slot
- locked  in  1  from token slot
- send  out  1  to token slot
- lock_line  out  1  to token slot
- unlock_line  out  1  to token slot
- ring_send  out  1  one-cycle pulse launching ring request
- ring_ret_valid  in  1  a request arrives back from the ring
- ring_ret_tag  in  addr_tag  returning tag
- ring_ret_index  in  addr_index  returning index
- starve  out  1  waited at least STARVE_LIMIT cycles
- busy  out  1  state != IDLE

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, core_tag/core_index 0, lock flag 0, wait counter 0. All pulse outputs and starve are 0, busy is 0, req_ready is 1.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch req_tag, req_index and req_lock; go to WAIT_TOKEN.
- WAIT_TOKEN:
  - send, lock_line and ring_send are combinational and are asserted only in the cycle where state==WAIT_TOKEN && may_send.
  - lock_line additionally requires the latched lock flag.
  - The next state is WAIT_RETURN.
  - Otherwise the wait counter increments and saturates.
- WAIT_RETURN:
  - Waits for ring_ret_valid with ring_ret_tag==core_tag && ring_ret_index==core_index. Non-matching returns are ignored.
  - On a match: done=1 for that cycle. Go to LOCKED if the lock flag is set, else IDLE.
- LOCKED:
  - req_ready = 0.
  - On unlock: unlock_line=1 for one cycle, clear the lock flag, go to IDLE.
  - The upstream slot keeps e0 valid while locked.
- unlock outside LOCKED is ignored; no unlock_line is emitted.
- The wait counter clears on every entry to WAIT_TOKEN.
- starve = (counter >= STARVE_LIMIT) && state==WAIT_TOKEN.
- If may_send and a matching ring_ret_valid occur in the same cycle, only the WAIT_TOKEN action applies. A return can never precede its own send.
- Latency: req_valid to send is at least 1 cycle (1 if may_send is already high in the cycle after acceptance).
- Asynchronous reset mid-operation returns to IDLE immediately and drops any lock intent.
- locked is only used for the LOCKED consistency check below.

Optional Feature:
- Macro: CACHE_TOKEN_CTRL_ASSERT_EN.
- Defined: include assertions that:
  - send never fires without may_send;
  - locked from the slot is high while in LOCKED one cycle after entry;
  - unlock_line is never asserted outside LOCKED.
- Undefined: no assertions; RTL behaviour is identical.

Decomposition:
- addr_tag, addr_index and ring_token come from the shared cache definitions package.
- Add to that package an enum ctrl_state {IDLE, WAIT_TOKEN, WAIT_RETURN, LOCKED}.
- One natural sub-module: cache_wait_counter, a saturating counter with clear and enable, parameterised by WAIT_W and STARVE_LIMIT, that outputs the starve compare.

Test Plan:
- may_send held 1; req tag=0x12 index=3 lock=0 → send/ring_send at cycle+1; ring return 0x12/3 at cycle+5 → done pulse; busy clears at the same edge.
- may_send held 0 for 70 cycles after acceptance → starve rises at wait count 64; may_send=1 → send fires, starve drops next cycle.
- lock=1 request → lock_line coincides with send; after return, LOCKED with req_ready=0; unlock → unlock_line pulse, back to IDLE.
- In WAIT_RETURN, return tag 0x13/3 then 0x12/4 → no done; 0x12/3 → done.
- unlock pulsed in IDLE and WAIT_TOKEN → unlock_line remains 0.
- rst_n low during WAIT_RETURN → all outputs at reset values immediately; next request handled normally.
